mdu_iterative: RTL
==================

Name: mdu_iterative

Overview:
- Iterative multiply/divide unit sitting between the register bank read ports and the register bank write port.
- Takes two 32-bit operands read from the bank plus a 6-bit destination register number.
- Computes the result over 32 cycles.
- Returns result, destination and a one-cycle write strobe that drives the bank's write data, write register and write-enable inputs.

Parameters:
- DATA_W, 32, operand/result width; the counter is sized for DATA_W iterations.
- REG_ADDR_W, 6, destination register number width (64-entry bank).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy==0.
- op  in  3  op[1:0]: 00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 REM (remainder); op[2] signed select (see Optional Feature).
- operand_a  in  DATA_W  multiplicand / dividend.
- operand_b  in  DATA_W  multiplier / divisor.
- dest_reg  in  REG_ADDR_W  destination register number.
- busy  out  1  high while computing (RUN state).
- done  out  1  one-cycle pulse when result becomes valid.
- result  out  DATA_W  final value; held until the next accepted start.
- result_reg  out  REG_ADDR_W  dest_reg captured at start; held like result.
- result_write  out  1  write-enable strobe for the bank; equals done && (result_reg != 0).

Behaviour:
- Reset (async, reset_n low):
  - State returns to IDLE.
  - busy, done, result_write are 0; result is 0; result_reg is 0; internal accumulators and counter are cleared.
  - A reset during RUN aborts the operation; no done pulse follows.
- States:
  - IDLE: start=1 captures operands, op and dest_reg, loads counter=DATA_W-1, then goes to RUN.
  - RUN: one shift-add (MUL/MULH) or restoring shift-subtract (DIV/REM) step per cycle; counter decrements. At counter==0 the final step completes and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, result and result_reg are valid. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back issue allowed).
- Latency:
  - Start accepted at edge N; done is high in the cycle after edge N+32.
  - One operation per 33 cycles, maximum throughput.
- start while busy=1 is ignored; no queuing.
- Input sampling: operands may change after the accepting edge without affecting the result.
- MUL/MULH: 64-bit unsigned product; MUL returns bits [31:0], MULH returns bits [63:32].
- DIV/REM: unsigned quotient / remainder.
- Divide by zero (operand_b==0, DIV/REM):
  - No RUN phase; goes IDLE->DONE directly, so done is high one cycle after acceptance.
  - DIV returns 0xFFFFFFFF; REM returns operand_a.
- dest_reg==0: operation runs and done pulses, but result_write stays 0 (register 0 is constant zero).
- result and result_reg update only on entry to DONE; they are stable between done pulses.

Optional Feature:
- Macro: MDU_SIGNED_OPS_EN.
- Defined:
  - op[2]=1 makes operands two's complement; magnitudes are computed, and the result is negated when operand signs differ.
  - The remainder takes the dividend's sign.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives DIV 0x80000000 and REM 0.
  - Signed divide by zero follows the unsigned rule.
  - MULH returns the signed high word.
- Not defined: op[2] is ignored and all ops are unsigned; no negation logic is synthesised.

Decomposition:
- Shared package mdu_pkg:
  - op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM, OP_SIGNED_BIT).
  - FSM state enum (IDLE, RUN, DONE).
  - DATA_W default constant.
  - Divide-by-zero quotient constant.
- Sub-module mdu_sign_fix:
  - Conditional two's-complement negate of a DATA_W value.
  - Instantiated for operand and result correction only under MDU_SIGNED_OPS_EN.

Test Plan:
- MUL 7 x 6, dest_reg=5:
  - busy high 32 cycles.
  - done at cycle 33 with result=42, result_reg=5, result_write=1.
- MULH 0xFFFFFFFF x 0xFFFFFFFF: result=0xFFFFFFFE. A follow-up MUL on the same operands gives 0x00000001.
- DIV 100 / 7: result=14. REM 100 / 7: result=2. Issue the second start in the DONE cycle and check back-to-back acceptance.
- DIV 5 / 0: done one cycle after start with result=0xFFFFFFFF. REM 5 / 0: result=5.
- Control corner cases:
  - start pulsed mid-RUN with different operands: ignored, first result intact.
  - reset_n low at cycle 10 of RUN: busy, done, result all 0 immediately, with no later done.
  - dest_reg=0: done=1, result_write=0.
- With MDU_SIGNED_OPS_EN:
  - DIV -7 / 2 gives 0xFFFFFFFD (-3); REM gives 0xFFFFFFFF (-1).
  - 0x80000000 / -1 gives 0x80000000.
  - Without the macro, the same stimulus gives the unsigned results.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op[1:0] encodings and the position of the signed-select bit in op
//   - FSM state enumeration
//   - default operand width and the divide-by-zero quotient value
package mdu_pkg;

   localparam int MDU_DATA_W = 32;

   localparam logic [1:0] OP_MUL  = 2'b00;  // low word of product
   localparam logic [1:0] OP_MULH = 2'b01;  // high word of product
   localparam logic [1:0] OP_DIV  = 2'b10;  // quotient
   localparam logic [1:0] OP_REM  = 2'b11;  // remainder
   localparam int OP_SIGNED_BIT = 2;

   localparam logic [MDU_DATA_W-1:0] DIV_ZERO_Q = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate.
// Ports:
//   negate  in   1       when high, output is -value
//   value   in   DATA_W  input word
//   fixed   out  DATA_W  value or its two's complement
module mdu_sign_fix #(
   parameter int DATA_W = 32
) (
   input  logic              negate,
   input  logic [DATA_W-1:0] value,
   output logic [DATA_W-1:0] fixed
);

   assign fixed = negate ? ({DATA_W{1'b0}} - value) : value;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit between the register bank read ports and
// its write port. One shift-add (MUL/MULH) or restoring shift-subtract
// (DIV/REM) step per clock, DATA_W steps per operation.
//
// Optional feature macro: MDU_SIGNED_OPS_EN
//   defined     : op[2]=1 treats operands as two's complement
//   not defined : op[2] ignored, all operations unsigned
//
// Ports:
//   clock         in   1           rising-edge clock
//   reset_n       in   1           asynchronous active-low reset
//   start         in   1           request, accepted when busy==0
//   op            in   3           op[1:0] MUL/MULH/DIV/REM, op[2] signed select
//   operand_a     in   DATA_W      multiplicand / dividend
//   operand_b     in   DATA_W      multiplier / divisor
//   dest_reg      in   REG_ADDR_W  destination register number
//   busy          out  1           high while iterating (RUN)
//   done          out  1           one-cycle pulse, result valid
//   result        out  DATA_W      final value, held until next completion
//   result_reg    out  REG_ADDR_W  destination captured at start
//   result_write  out  1           bank write enable, done && result_reg != 0
module mdu_iterative
   import mdu_pkg::*;
#(
   parameter int DATA_W     = MDU_DATA_W,
   parameter int REG_ADDR_W = 6
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_W-1:0]     operand_a,
   input  logic [DATA_W-1:0]     operand_b,
   input  logic [REG_ADDR_W-1:0] dest_reg,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_W-1:0]     result,
   output logic [REG_ADDR_W-1:0] result_reg,
   output logic                  result_write
);

   localparam int CNT_W = $clog2(DATA_W);

   mdu_state_e            state;
   logic [CNT_W-1:0]      count;
   logic [DATA_W-1:0]     acc_hi;   // product high word / partial remainder
   logic [DATA_W-1:0]     acc_lo;   // multiplier / dividend-quotient shifter
   logic [DATA_W-1:0]     opnd_b;   // multiplicand / divisor magnitude
   logic [1:0]            op_q;
   logic [REG_ADDR_W-1:0] dest_q;

   logic                  div_by_zero;
   logic [DATA_W-1:0]     mag_a;
   logic [DATA_W-1:0]     mag_b;
   logic [DATA_W-1:0]     step_hi;
   logic [DATA_W-1:0]     step_lo;
   logic [DATA_W-1:0]     raw_res;
   logic [DATA_W-1:0]     final_res;
   logic [DATA_W:0]       mul_sum;
   logic [DATA_W:0]       div_shift;
   logic [DATA_W+1:0]     div_diff;
   logic                  unused_div_bit;

   // Divide by zero skips the iteration entirely.
   assign div_by_zero = op[1] && (operand_b == '0);

   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
      div_shift = {acc_hi, acc_lo[DATA_W-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd_b};
      if (op_q[1]) begin
         // Restoring step: keep the shifted remainder when the trial
         // subtraction goes negative; the quotient bit shifts in at the bottom.
         step_hi = div_diff[DATA_W+1] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
         step_lo = {acc_lo[DATA_W-2:0], ~div_diff[DATA_W+1]};
      end else begin
         // Shift-add: carry of the add becomes the new top bit of the product.
         step_hi = mul_sum[DATA_W:1];
         step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
      end
   end

   // A remainder below the divisor never needs bit DATA_W of the difference.
   assign unused_div_bit = div_diff[DATA_W];

   // MUL and DIV take the low register, MULH and REM the high one.
   assign raw_res = op_q[0] ? step_hi : step_lo;

`ifdef MDU_SIGNED_OPS_EN
   logic              sign_a;
   logic              sign_b;
   logic              neg_res_d;
   logic              neg_res_q;
   logic [DATA_W-1:0] fixed_res;

   assign sign_a    = op[OP_SIGNED_BIT] & operand_a[DATA_W-1];
   assign sign_b    = op[OP_SIGNED_BIT] & operand_b[DATA_W-1];
   // Remainder follows the dividend; product and quotient follow the sign xor.
   assign neg_res_d = (op[1:0] == OP_REM) ? sign_a : (sign_a ^ sign_b);

   mdu_sign_fix #(.DATA_W(DATA_W)) u_fix_a (.negate(sign_a),    .value(operand_a), .fixed(mag_a));
   mdu_sign_fix #(.DATA_W(DATA_W)) u_fix_b (.negate(sign_b),    .value(operand_b), .fixed(mag_b));
   mdu_sign_fix #(.DATA_W(DATA_W)) u_fix_r (.negate(neg_res_q), .value(raw_res),   .fixed(fixed_res));

   // Negating the 64-bit product only carries into the high word when the
   // low word is zero; otherwise the high word is just inverted.
   assign final_res = (op_q == OP_MULH && neg_res_q && step_lo != '0) ? ~step_hi : fixed_res;
`else
   logic unused_sign;
   assign unused_sign = op[OP_SIGNED_BIT];
   assign mag_a       = operand_a;
   assign mag_b       = operand_b;
   assign final_res   = raw_res;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         count        <= '0;
         acc_hi       <= '0;
         acc_lo       <= '0;
         opnd_b       <= '0;
         op_q         <= OP_MUL;
         dest_q       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         result_reg   <= '0;
         result_write <= 1'b0;
`ifdef MDU_SIGNED_OPS_EN
         neg_res_q    <= 1'b0;
`endif
      end else begin
         done         <= 1'b0;
         result_write <= 1'b0;
         case (state)
            RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count - CNT_W'(1);
               if (count == '0) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  result       <= final_res;
                  result_reg   <= dest_q;
                  result_write <= (dest_q != '0);
               end
            end
            default: begin
               // IDLE and DONE both accept a new request.
               if (start) begin
                  op_q   <= op[1:0];
                  dest_q <= dest_reg;
                  if (div_by_zero) begin
                     state        <= DONE;
                     done         <= 1'b1;
                     result       <= op[0] ? operand_a : DATA_W'(DIV_ZERO_Q);
                     result_reg   <= dest_reg;
                     result_write <= (dest_reg != '0);
                  end else begin
                     state  <= RUN;
                     busy   <= 1'b1;
                     count  <= CNT_W'(DATA_W - 1);
                     acc_hi <= '0;
                     acc_lo <= mag_a;
                     opnd_b <= mag_b;
`ifdef MDU_SIGNED_OPS_EN
                     neg_res_q <= neg_res_d;
`endif
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
